// File: rtl/div_unit_if.sv
// Operand/result bundle between register-read, the divide unit and writeback.
// Signal names follow the issue-stage and writeback naming of the pipeline.
interface div_unit_if #(
    parameter int ROB_W = 3
);
    logic                  RR_valid;
    logic [2:0]            RR_fu_sel;
    logic [2:0]            RR_f3;
    logic [31:0]           RR_rs1_data;
    logic [31:0]           RR_rs2_data;
    logic [6:0]            RR_rd;
    logic [ROB_W-1:0]      RR_rob_idx;
    logic                  div_ready;
    logic                  mispredict;
    logic [2**ROB_W-1:0]   flush_mask;
    logic                  WB_ready;
    logic                  div_valid;
    logic [31:0]           div_data;
    logic [6:0]            div_rd;
    logic [ROB_W-1:0]      div_rob_idx;

    modport master (
        output RR_valid, RR_fu_sel, RR_f3, RR_rs1_data, RR_rs2_data, RR_rd, RR_rob_idx,
        output mispredict, flush_mask, WB_ready,
        input  div_ready, div_valid, div_data, div_rd, div_rob_idx
    );

    modport slave (
        input  RR_valid, RR_fu_sel, RR_f3, RR_rs1_data, RR_rs2_data, RR_rd, RR_rob_idx,
        input  mispredict, flush_mask, WB_ready,
        output div_ready, div_valid, div_data, div_rd, div_rob_idx
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring radix-2, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |rs1| < |rs2|.
module div_unit #(
    parameter int FU_ID = 2,
    parameter int ROB_W = 3
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nx;
    logic [31:0]      quo_r, rem_r, dvs_r, data_r;
    logic [5:0]       cnt_r;
    logic [1:0]       f3_r;
    logic             q_neg_r, r_neg_r;
    logic [6:0]       rd_r;
    logic [ROB_W-1:0] rob_r;

    logic        signed_op, a_neg, b_neg, div_zero, ovf, early, fast;
    logic        accept, flush_hit;
    logic [31:0] a_abs, b_abs, fast_res;

    assign signed_op = ~bus.RR_f3[0];
    assign a_neg     = signed_op & bus.RR_rs1_data[31];
    assign b_neg     = signed_op & bus.RR_rs2_data[31];
    assign a_abs     = a_neg ? -bus.RR_rs1_data : bus.RR_rs1_data;
    assign b_abs     = b_neg ? -bus.RR_rs2_data : bus.RR_rs2_data;
    assign div_zero  = (bus.RR_rs2_data == 32'd0);
    assign ovf       = signed_op && (bus.RR_rs1_data == 32'h8000_0000) &&
                       (bus.RR_rs2_data == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    assign early     = (a_abs < b_abs);
`else
    assign early     = 1'b0;
`endif
    assign fast      = div_zero | ovf | early;

    assign accept    = (state == IDLE) && bus.RR_valid && (bus.RR_fu_sel == 3'(FU_ID)) &&
                       !(bus.mispredict && bus.flush_mask[bus.RR_rob_idx]);
    assign flush_hit = bus.mispredict && bus.flush_mask[rob_r];

    // Results that need no iteration; the early-out case keeps rs1 unsigned-as-is.
    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = bus.RR_f3[1] ? bus.RR_rs1_data : 32'hFFFF_FFFF;
        else if (ovf)
            fast_res = bus.RR_f3[1] ? 32'd0 : 32'h8000_0000;
        else
            fast_res = bus.RR_f3[1] ? bus.RR_rs1_data : 32'd0;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [33:0] diff;
    logic        ge;
    logic [31:0] rem_nx, quo_nx, q_fin, r_fin;

    assign diff   = {1'b0, rem_r, quo_r[31]} - {2'b00, dvs_r};
    assign ge     = ~diff[33];
    assign rem_nx = ge ? diff[31:0] : {rem_r[30:0], quo_r[31]};
    assign quo_nx = {quo_r[30:0], ge};
    assign q_fin  = q_neg_r ? -quo_nx : quo_nx;
    assign r_fin  = r_neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = fast ? DONE : CALC;
            CALC: begin
                if (flush_hit)              state_nx = IDLE;
                else if (cnt_r == 6'd31)    state_nx = DONE;
            end
            DONE: begin
                if (flush_hit)              state_nx = IDLE;
                else if (bus.WB_ready)      state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_r   <= '0;
            rem_r   <= '0;
            dvs_r   <= '0;
            data_r  <= '0;
            cnt_r   <= '0;
            f3_r    <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            rd_r    <= '0;
            rob_r   <= '0;
        end else if (accept) begin
            quo_r   <= a_abs;
            rem_r   <= '0;
            dvs_r   <= b_abs;
            cnt_r   <= '0;
            f3_r    <= bus.RR_f3[1:0];
            q_neg_r <= a_neg ^ b_neg;
            r_neg_r <= a_neg;
            rd_r    <= bus.RR_rd;
            rob_r   <= bus.RR_rob_idx;
            if (fast) data_r <= fast_res;
        end else if (state == CALC) begin
            quo_r <= quo_nx;
            rem_r <= rem_nx;
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == 6'd31) data_r <= f3_r[1] ? r_fin : q_fin;
        end
    end

    assign bus.div_ready   = (state == IDLE);
    assign bus.div_valid   = (state == DONE);
    assign bus.div_data    = data_r;
    assign bus.div_rd      = rd_r;
    assign bus.div_rob_idx = rob_r;

    logic unused_ok;
    assign unused_ok = ^{bus.RR_f3[2], diff[32], f3_r[0]};
endmodule
